mod_n_stream_detector: RTL
==========================

Name: mod_n_stream_detector

Overview:
Parametrised divisibility detector for a binary number streamed W bits per cycle. It tracks the running value mod DIVISOR and flags when the number received so far is an exact multiple of DIVISOR. It supports both MSB-first and LSB-first streams, valid-qualified input with gaps, and in-band restart of a new number. It serves as the generic successor to the fixed single-bit divide-by-3 FSM in the serial-protocol checker blocks.

Parameters:
DIVISOR, 3, modulus N; legal range 2..65535 (elaboration error otherwise)
W, 1, bits consumed per valid beat; legal range 1..8
LSB_FIRST, 0, 0 = MSB-first (Horner), 1 = LSB-first (weighted sum)
RW, $clog2(DIVISOR), derived remainder width; never overridden

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
din_valid  in  1  din holds a beat of the current number
din  in  W  beat; din[W-1] is the most significant bit within the beat in both modes
start  in  1  qualified by din_valid: this beat is the first beat of a new number
dout  out  1  number received so far is divisible by DIVISOR
remainder  out  RW  running value mod DIVISOR
active  out  1  at least one beat accepted since reset

Behaviour:
- One clock, one synchronous active-high reset. On reset: state = IDLE, remainder = 0, weight = 1 mod N, dout = 0, active = 0. Reset wins over every other input in the same cycle. Reset mid-number discards all history.
- States (package enum): IDLE (no beat since reset), RUN.
- Beat accepted on a clk edge when din_valid = 1 and reset = 0. Idle cycles (din_valid = 0) hold all state. start is ignored when din_valid = 0.
- First-beat rule: a beat accepted in IDLE, or with start = 1, begins a new number. Then r' = din mod N. In LSB-first mode, w' = 2^W mod N. State goes to RUN.
- Continuing beat in RUN with start = 0:
  - MSB-first: r' = (r * 2^W + din) mod N.
  - LSB-first: r' = (r + din * w) mod N, w' = (w * 2^W) mod N. w holds the weight of the next beat's LSB.
- Arithmetic: intermediates sized at RW+W+1 bits minimum, with no truncation before reduction. Reduction is exact for all din values, including din >= N.
- Outputs are driven purely from registered state. Latency is 1 cycle: the edge that accepts a beat updates remainder/dout, and they are visible immediately after that edge.
- dout = active && (remainder == 0). dout = 0 in IDLE, so the empty number is not divisible.
- active = (state == RUN).
- The weight register exists only when LSB_FIRST = 1. When LSB_FIRST = 0 it is tied off and not synthesised.
- The value is unbounded in length: there is no overflow, and wrap-around happens only mod N.
- start on the very first beat after reset is equivalent to a plain first beat.

Decomposition:
- Package mod_stream_pkg holds:
  - typedef enum logic {IDLE, RUN} state_t.
  - Pure function mod_reduce(value, N).
  - Localparam helper computing 2^W mod N.
- Sub-module mod_step: combinational; inputs r, w, din, first; outputs r_next, w_next. It is instantiated once and unit-tested standalone across the full parameter grid.

Test Plan:
- N=3, W=1, MSB: reset, then bits 1,1,0,1 -> remainder 1,0,0,1; dout 0,1,1,0 (values 1,3,6,13).
- N=5, W=2, MSB: beats 2'b10, 2'b10 -> remainder 2,0; dout 0,1 (value 10). Then start=1 with beat 2'b11 -> remainder 3, dout 0.
- N=3, W=1, LSB_FIRST=1: bits 1,1,0,1 -> remainder 1,0,0,2; dout 0,1,1,0 (values 1,3,3,11).
- N=7, W=1, MSB: bits 1,1 with din_valid low for 3 cycles between them -> outputs hold 1 across the gap, then remainder 3. start=1 with din_valid=0 -> no change.
- N=3, W=1, MSB: feed 1,1 (dout=1), assert reset together with din_valid=1, din=1 -> remainder 0, dout 0, active 0. Next bit 0 -> remainder 0, dout 1, active 1.
- N=9, W=8, MSB: beats 8'hFF, 8'hFF -> remainder 3, then 65535 mod 9 = 6, dout 0. Compare against the reference model over 10k random beats with random start and valid, for N in {2,3,10,255} and both modes.

Source files
------------

// File: rtl/mod_stream_pkg.sv
// Shared types and arithmetic helpers for the streamed mod-N divisibility detector.
package mod_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned MIN_DIVISOR = 2;
   localparam int unsigned MAX_DIVISOR = 65535;
   localparam int unsigned MIN_W       = 1;
   localparam int unsigned MAX_W       = 8;

   // Exact reduction of a zero-extended intermediate; n is an elaboration constant at every call.
   function automatic logic [31:0] mod_reduce(input logic [31:0] value, input logic [31:0] n);
      return value % n;
   endfunction

   // Weight of the second beat's LSB in LSB-first mode.
   function automatic int unsigned pow2_mod(input int unsigned w, input int unsigned n);
      return (32'd1 << w) % n;
   endfunction

endpackage

// File: rtl/mod_step.sv
// One beat of the mod-N recurrence: next remainder (and next weight in LSB-first mode).
module mod_step
   import mod_stream_pkg::*;
#(
   parameter int unsigned DIVISOR   = 3,
   parameter int unsigned W         = 1,
   parameter bit          LSB_FIRST = 1'b0,
   parameter int unsigned RW        = $clog2(DIVISOR)
) (
   input  logic [RW-1:0] r,
   input  logic [RW-1:0] w,
   input  logic [W-1:0]  din,
   input  logic          first,
   output logic [RW-1:0] r_next,
   output logic [RW-1:0] w_next
);

   // Wide enough for (N-1)*2^W + (2^W-1) and (N-1) + (2^W-1)*(N-1) without truncation.
   localparam int unsigned IW = RW + W + 1;
   localparam logic [RW-1:0] FIRST_WEIGHT = RW'(pow2_mod(W, DIVISOR));

   logic [IW-1:0] acc;

   generate
      if (LSB_FIRST) begin : g_lsb
         logic [IW-1:0] wacc;

         always_comb begin
            acc  = '0;
            wacc = '0;
            if (first) begin
               acc    = IW'(din);
               w_next = FIRST_WEIGHT;
            end else begin
               acc    = IW'(r) + (IW'(din) * IW'(w));
               wacc   = IW'(w) << W;
               w_next = RW'(mod_reduce(32'(wacc), 32'(DIVISOR)));
            end
         end
      end else begin : g_msb
         logic unused_w;
         assign unused_w = ^w;

         always_comb begin
            acc    = '0;
            w_next = '0;
            if (first) begin
               acc = IW'(din);
            end else begin
               acc = (IW'(r) << W) | IW'(din);
            end
         end
      end
   endgenerate

   assign r_next = RW'(mod_reduce(32'(acc), 32'(DIVISOR)));

endmodule

// File: rtl/mod_n_stream_detector.sv
// Flags when a binary number streamed W bits per valid beat is an exact multiple of DIVISOR.
module mod_n_stream_detector
   import mod_stream_pkg::*;
#(
   parameter int unsigned DIVISOR   = 3,
   parameter int unsigned W         = 1,
   parameter bit          LSB_FIRST = 1'b0,
   parameter int unsigned RW        = $clog2(DIVISOR)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          din_valid,
   input  logic [W-1:0]  din,
   input  logic          start,
   output logic          dout,
   output logic [RW-1:0] remainder,
   output logic          active
);

   generate
      if (DIVISOR < MIN_DIVISOR || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
         $error("mod_n_stream_detector: DIVISOR must be in 2..65535");
      end
      if (W < MIN_W || W > MAX_W) begin : g_bad_width
         $error("mod_n_stream_detector: W must be in 1..8");
      end
   endgenerate

   state_t        state_q, state_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [RW-1:0] weight_q;
   logic [RW-1:0] r_step, w_step;
   logic          first;

   // A beat in IDLE always opens a number, so start after reset changes nothing.
   assign first = (state_q == IDLE) || start;

   mod_step #(
      .DIVISOR   (DIVISOR),
      .W         (W),
      .LSB_FIRST (LSB_FIRST),
      .RW        (RW)
   ) u_step (
      .r      (rem_q),
      .w      (weight_q),
      .din    (din),
      .first  (first),
      .r_next (r_step),
      .w_next (w_step)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (din_valid) begin
         state_d = RUN;
         rem_d   = r_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   generate
      if (LSB_FIRST) begin : g_weight
         logic [RW-1:0] weight_d;

         always_comb begin
            weight_d = weight_q;
            if (din_valid) begin
               weight_d = w_step;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               weight_q <= RW'(1 % DIVISOR);
            end else begin
               weight_q <= weight_d;
            end
         end
      end else begin : g_no_weight
         logic unused_w_step;
         assign unused_w_step = ^w_step;
         assign weight_q      = '0;
      end
   endgenerate

   assign active    = (state_q == RUN);
   assign dout      = active && (rem_q == '0);
   assign remainder = rem_q;

endmodule
